ps2_dir_decoder: RTL and testbench
==================================

PS2_DIR_DECODER -- requirements
Module: ps2_dir_decoder

Interface
REQ-001 SHALL have parameter STEP_DIV, default 2_500_000, meaning clk cycles per movement step; legal range 2..2^24.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port ps2_data  input  8  scan-code byte from the PS/2 receiver, valid while ps2_ready is high.
REQ-005 SHALL have port ps2_ready  input  1  byte-available level from the PS/2 receiver.
REQ-006 SHALL have port dir  output  2  current direction: 00 up, 01 down, 10 left, 11 right.
REQ-007 SHALL have port moving  output  1  high while at least one direction key is held.
REQ-008 SHALL have port step  output  1  single-cycle movement strobe for the Pac-Man position controller.
REQ-009 SHALL have port held  output  4  held-key mask: bit0 up, bit1 down, bit2 left, bit3 right.
REQ-010 SHALL have port paused  output  1  pause level, toggled by Space.

Function
REQ-011 SHALL register ps2_ready once; a byte SHALL be accepted only in a cycle where ps2_ready=1 and the registered copy=0 (rising edge), so a level held high yields exactly one acceptance.
REQ-012 SHALL decode scan-code set 2 with a 4-state prefix FSM: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0).
REQ-013 SHALL apply these transitions on each accepted byte: E0 from any state -> EXT; F0 from IDLE or BRK -> BRK; F0 from EXT or EXT_BRK -> EXT_BRK; any other byte -> IDLE after it is processed.
REQ-014 SHALL map keys as follows: E0 75 or 1D = up; E0 72 or 1B = down; E0 6B or 1C = left; E0 74 or 23 = right; 29 = Space.
REQ-015 SHALL treat EXT_BRK as a break only for arrow codes, and BRK as a break only for the W/A/S/D/Space codes; unmapped codes and prefix/code mismatches SHALL have no effect other than returning to IDLE.
REQ-016 SHALL on a direction make set the held bit and set dir to that key (latest-press priority); a make of an already-held key changes nothing (typematic repeat).
REQ-017 SHALL on a direction break clear the held bit; if the released key equals dir and other bits remain held, dir SHALL take the remaining key with priority up>down>left>right; if none remain, dir SHALL be retained.
REQ-018 SHALL drive moving = OR of held.
REQ-019 SHALL update held, dir, moving and paused one cycle after the accepting cycle, so they are visible from the cycle after that edge.
REQ-020 SHALL toggle paused on a Space make only; a Space break SHALL have no effect.
REQ-021 SHALL keep a 24-bit step counter: cleared to 0 whenever moving=0; held unchanged while paused=1; otherwise incremented each cycle, wrapping STEP_DIV-1 -> 0.
REQ-022 SHALL assert step for exactly one cycle when the counter equals STEP_DIV-1, moving=1 and paused=0; the first step SHALL occur STEP_DIV cycles after moving rises.
REQ-023 SHALL let a byte accepted in the same cycle as a step strobe take effect normally, with no strobe lost or duplicated.
REQ-024 SHALL keep the counter value when dir changes while moving stays 1, so cadence is not restarted.

Reset
REQ-025 SHALL, while rst=1 (asynchronous), force: FSM=IDLE, held=0000, dir=00, moving=0, step=0, paused=0, counter=0, registered ps2_ready=0.
REQ-026 SHALL, after rst falls, accept a byte only on a fresh ready rising edge; a ready level high across reset release SHALL be accepted in the first post-reset cycle.
REQ-027 SHALL, if reset is asserted mid-prefix (e.g. after E0), discard the prefix; the next byte SHALL be decoded from IDLE.

Verification (STEP_DIV=4)
REQ-028 SHALL test: E0,74 -> held=1000, dir=11, moving=1; steps 4 cycles after moving rises, then every 4 cycles.
REQ-029 SHALL test: 1D then 1C, then F0,1C -> dir=10 then falls back to dir=00; held 0001->0101->0001; step cadence is unbroken.
REQ-030 SHALL test: E0,F0,74 with right held -> held=0000, moving=0, dir stays 11, counter=0, no further step.
REQ-031 SHALL test: 29, F0,29, 29 -> paused goes 1 and then 0; while paused with a key held, step=0 and the counter is frozen, resuming from the same value.
REQ-032 SHALL test: ps2_ready held high for 10 cycles with data 1B -> exactly one acceptance, held=0010.
REQ-033 SHALL test: E0 then rst pulse then 75 -> no effect (75 decoded from IDLE is unmapped), held=0000.

Source files
------------

// File: rtl/ps2_dir_decoder.sv
// PS/2 scan-code set 2 decoder for Pac-Man direction keys (arrows + WASD) and Space pause,
// with a paced single-cycle movement strobe.
module ps2_dir_decoder #(
  parameter int unsigned STEP_DIV = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ps2_data,
  input  logic       ps2_ready,
  output logic [1:0] dir,
  output logic       moving,
  output logic       step,
  output logic [3:0] held,
  output logic       paused
);
  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  localparam logic [23:0] CNT_LAST = 24'(STEP_DIV - 1);

  state_t      state_q, state_d;
  logic        rdy_q;
  logic        accept;
  logic [3:0]  held_q, held_d;
  logic [1:0]  dir_q, dir_d;
  logic        paused_q, paused_d;
  logic        moving_q, step_q;
  logic [23:0] cnt_q, cnt_d;
  logic        key_vld, key_brk, space_vld;
  logic [1:0]  key_idx;

  function automatic logic [1:0] first_held(input logic [3:0] h);
    if (h[0])      return 2'd0;
    else if (h[1]) return 2'd1;
    else if (h[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  assign accept = ps2_ready & ~rdy_q;

  // Arrow codes only count after an E0 prefix, WASD/Space only without one.
  always_comb begin
    key_vld   = 1'b0;
    key_idx   = 2'd0;
    space_vld = 1'b0;
    key_brk   = (state_q == S_EXT_BRK) || (state_q == S_BRK);
    case (state_q)
      S_EXT, S_EXT_BRK: begin
        case (ps2_data)
          8'h75:   begin key_vld = 1'b1; key_idx = 2'd0; end
          8'h72:   begin key_vld = 1'b1; key_idx = 2'd1; end
          8'h6B:   begin key_vld = 1'b1; key_idx = 2'd2; end
          8'h74:   begin key_vld = 1'b1; key_idx = 2'd3; end
          default: ;
        endcase
      end
      default: begin
        case (ps2_data)
          8'h1D:   begin key_vld = 1'b1; key_idx = 2'd0; end
          8'h1B:   begin key_vld = 1'b1; key_idx = 2'd1; end
          8'h1C:   begin key_vld = 1'b1; key_idx = 2'd2; end
          8'h23:   begin key_vld = 1'b1; key_idx = 2'd3; end
          8'h29:   space_vld = 1'b1;
          default: ;
        endcase
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    held_d   = held_q;
    dir_d    = dir_q;
    paused_d = paused_q;
    if (accept) begin
      if (ps2_data == 8'hE0) begin
        state_d = S_EXT;
      end else if (ps2_data == 8'hF0) begin
        state_d = ((state_q == S_EXT) || (state_q == S_EXT_BRK)) ? S_EXT_BRK : S_BRK;
      end else begin
        state_d = S_IDLE;
        if (key_vld && !key_brk && !held_q[key_idx]) begin
          held_d[key_idx] = 1'b1;
          dir_d           = key_idx;
        end else if (key_vld && key_brk) begin
          held_d[key_idx] = 1'b0;
          // Releasing the active key falls back to a still-held one; otherwise keep facing.
          if ((key_idx == dir_q) && (held_d != 4'b0000))
            dir_d = first_held(held_d);
        end
        if (space_vld && !key_brk)
          paused_d = ~paused_q;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!moving_q)
      cnt_d = '0;
    else if (!paused_q)
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 24'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rdy_q    <= 1'b0;
      held_q   <= 4'b0000;
      dir_q    <= 2'b00;
      paused_q <= 1'b0;
      moving_q <= 1'b0;
      step_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= ps2_ready;
      held_q   <= held_d;
      dir_q    <= dir_d;
      paused_q <= paused_d;
      moving_q <= |held_d;
      step_q   <= moving_q & ~paused_q & (cnt_q == CNT_LAST);
      cnt_q    <= cnt_d;
    end
  end

  assign dir    = dir_q;
  assign moving = moving_q;
  assign step   = step_q;
  assign held   = held_q;
  assign paused = paused_q;

endmodule

// File: tb/tb_ps2_dir_decoder.sv
// Bench for ps2_dir_decoder: directed key scenarios plus random byte streams,
// checked every cycle against a key-event model and pinned with literal expectations.
module tb_ps2_dir_decoder;
  localparam int DIV = 4;
  localparam logic [8:0] M_DIR  = 9'b110000000;
  localparam logic [8:0] M_MOV  = 9'b001000000;
  localparam logic [8:0] M_STEP = 9'b000100000;
  localparam logic [8:0] M_HELD = 9'b000011110;
  localparam logic [8:0] M_PAU  = 9'b000000001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_ready = 1'b0;
  logic [1:0] dir;
  logic       moving, step, paused;
  logic [3:0] held;

  always #5 clk = ~clk;

  ps2_dir_decoder #(.STEP_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
    .dir(dir), .moving(moving), .step(step), .held(held), .paused(paused)
  );

  function automatic logic [8:0] pack(input logic [1:0] d, input logic mv, input logic st,
                                      input logic [3:0] h, input logic p);
    return {d, mv, st, h, p};
  endfunction

  // Behavioural model: prefix flags, held-key set, pause flag, count of active moving cycles.
  logic [3:0] m_held;
  logic [1:0] m_dir;
  logic       m_paused, m_step, m_rdy_prev, m_ext, m_brk;
  int         m_run;

  function automatic void model_byte(input logic [7:0] b);
    int  k;
    bit  sp;
    if (b == 8'hE0) begin
      m_ext = 1'b1; m_brk = 1'b0;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      k  = -1;
      sp = 1'b0;
      if (m_ext) begin
        if (b == 8'h75) k = 0;
        if (b == 8'h72) k = 1;
        if (b == 8'h6B) k = 2;
        if (b == 8'h74) k = 3;
      end else begin
        if (b == 8'h1D) k = 0;
        if (b == 8'h1B) k = 1;
        if (b == 8'h1C) k = 2;
        if (b == 8'h23) k = 3;
        if (b == 8'h29) sp = 1'b1;
      end
      if (k >= 0) begin
        if (!m_brk) begin
          if (!m_held[k]) begin
            m_held[k] = 1'b1;
            m_dir     = 2'(k);
          end
        end else begin
          m_held[k] = 1'b0;
          if (int'(m_dir) == k && m_held != 4'b0000) begin
            for (int i = 3; i >= 0; i--)
              if (m_held[i]) m_dir = 2'(i);
          end
        end
      end
      if (sp && !m_brk) m_paused = !m_paused;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_held = 4'b0000; m_dir = 2'b00; m_paused = 1'b0; m_step = 1'b0;
      m_rdy_prev = 1'b0; m_ext = 1'b0; m_brk = 1'b0; m_run = 0;
    end else begin
      m_step = (m_held != 4'b0000) && !m_paused && ((m_run % DIV) == DIV - 1);
      if (m_held == 4'b0000) m_run = 0;
      else if (!m_paused)    m_run = m_run + 1;
      if (ps2_ready && !m_rdy_prev) model_byte(ps2_data);
      m_rdy_prev = ps2_ready;
    end
  end

  // Single compare process: model check every cycle, plus literal requests from the stimulus.
  int         total = 0, bad = 0;
  int         lit_seq = 0, lit_seen = 0;
  string      lit_name;
  logic [8:0] lit_exp, lit_mask;
  logic [8:0] act_v, exp_v;
  bit         chk_en = 1'b0;

  always @(negedge clk) begin
    #2;
    act_v = pack(dir, moving, step, held, paused);
    if (chk_en && !rst) begin
      exp_v = pack(m_dir, |m_held, m_step, m_held, m_paused);
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL model t=%0t got dir/mov/step/held/pause=%b want=%b", $time, act_v, exp_v);
      end
    end
    if (lit_seq != lit_seen) begin
      lit_seen = lit_seq;
      total++;
      if ((act_v & lit_mask) !== (lit_exp & lit_mask)) begin
        bad++;
        $display("FAIL %s t=%0t got=%b want=%b mask=%b", lit_name, $time, act_v, lit_exp, lit_mask);
      end
    end
  end

  task automatic lit(input string nm, input logic [8:0] e, input logic [8:0] m);
    lit_name = nm; lit_exp = e; lit_mask = m;
    lit_seq++;
    while (lit_seen != lit_seq) #1;
  endtask

  task automatic send(input logic [7:0] b);
    ps2_data  = b;
    ps2_ready = 1'b1;
    @(negedge clk);
    ps2_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ps2_ready = 1'b0;
    #1;
    lit("reset_state", 9'b0, 9'h1FF);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [7:0] codes [14];
  logic [7:0] b;

  initial begin
    codes = '{8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74,
              8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h00};
    do_reset();
    chk_en = 1'b1;

    // Right arrow make and step cadence
    send(8'hE0); send(8'h74);
    lit("right_make", pack(2'b11, 1'b1, 1'b0, 4'b1000, 1'b0), M_DIR | M_MOV | M_HELD);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      lit("right_cadence", pack(2'b00, 1'b0, (i == 3 || i == 7), 4'b0, 1'b0), M_STEP);
    end

    // Right arrow break stops motion, keeps facing
    send(8'hE0); send(8'hF0); send(8'h74);
    lit("right_break", pack(2'b11, 1'b0, 1'b0, 4'b0000, 1'b0), M_DIR | M_MOV | M_HELD);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      lit("stopped_no_step", 9'b0, M_STEP);
    end

    // W then A, release A falls back to up
    do_reset();
    send(8'h1D);
    lit("w_make", pack(2'b00, 1'b1, 1'b0, 4'b0001, 1'b0), M_DIR | M_MOV | M_HELD);
    send(8'h1C);
    lit("a_make", pack(2'b10, 1'b1, 1'b0, 4'b0101, 1'b0), M_DIR | M_HELD);
    send(8'hF0); send(8'h1C);
    lit("a_break", pack(2'b00, 1'b1, 1'b0, 4'b0001, 1'b0), M_DIR | M_MOV | M_HELD);
    repeat (6) @(negedge clk);

    // Space toggles pause; break ignored; pause freezes the step pacing
    do_reset();
    send(8'h29);
    lit("space_pause", pack(2'b00, 1'b0, 1'b0, 4'b0, 1'b1), M_PAU);
    send(8'hF0); send(8'h29);
    lit("space_break_ignored", pack(2'b00, 1'b0, 1'b0, 4'b0, 1'b1), M_PAU);
    send(8'h29);
    lit("space_resume", 9'b0, M_PAU);
    send(8'h23);
    @(negedge clk);
    send(8'h29);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      lit("paused_no_step", pack(2'b11, 1'b1, 1'b0, 4'b1000, 1'b1), M_STEP | M_MOV | M_PAU | M_DIR);
    end
    send(8'h29);
    repeat (10) @(negedge clk);

    // Ready level held high: single acceptance
    do_reset();
    ps2_data = 8'h1B; ps2_ready = 1'b1;
    repeat (10) @(negedge clk);
    ps2_ready = 1'b0;
    @(negedge clk);
    lit("level_s_once", pack(2'b01, 1'b1, 1'b0, 4'b0010, 1'b0), M_DIR | M_HELD);
    do_reset();
    ps2_data = 8'h29; ps2_ready = 1'b1;
    repeat (10) @(negedge clk);
    ps2_ready = 1'b0;
    @(negedge clk);
    lit("level_space_once", pack(2'b00, 1'b0, 1'b0, 4'b0, 1'b1), M_PAU);

    // Reset mid-prefix discards E0
    do_reset();
    send(8'hE0);
    do_reset();
    send(8'h75);
    lit("prefix_discarded", 9'b0, M_HELD | M_MOV);

    // Ready already high at reset release
    @(negedge clk);
    rst = 1'b1; ps2_data = 8'h1D; ps2_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ps2_ready = 1'b0;
    @(negedge clk);
    lit("ready_across_reset", pack(2'b00, 1'b1, 1'b0, 4'b0001, 1'b0), M_HELD | M_MOV);

    // Random byte streams
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) < 2) do_reset();
      b = codes[$urandom_range(0, 13)];
      if (b == 8'h00) b = 8'($urandom_range(0, 255));
      ps2_data  = b;
      ps2_ready = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      ps2_ready = 1'b0;
      repeat ($urandom_range(1, 6)) @(negedge clk);
    end

    @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
